twi_slave: RTL and testbench

- TWI (I2C) target that answers `twi_master` transactions on the shared `scl`/`sda` pair.
- It owns one 7-bit chip address and exposes a 256-entry byte register space to a local host through a simple read/write strobe interface.
- It supports two transaction types:
  - Register write: chip address (W), register pointer, one or more data bytes.
  - Combined register read: chip address (W), register pointer, repeated START, chip address (R), data bytes.
- Bus lines are oversampled on `clk`; the block never drives `scl`.

---
 rtl/twi_pkg.sv | 27 ++
 rtl/twi_sync_edge.sv | 38 +++
 rtl/twi_slave.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_twi_slave.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/twi_pkg.sv
// -----------------------------------------------------------------------------
// twi_pkg
// Shared definitions for the TWI (I2C) target:
//   - twi_slv_state_t : protocol state machine encoding
//   - TWI_RD / TWI_WR : value of the R/W bit in the address byte
//   - twi_tick_t      : type of clk-cycle timing constants and counters
// -----------------------------------------------------------------------------
package twi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,      // waiting for START
    ST_ADDR,      // shifting in chip address + R/W
    ST_ADDR_ACK,  // acknowledging our address
    ST_WR_RX,     // receiving pointer or data byte
    ST_WR_ACK,    // acknowledging a received byte
    ST_RD_TX,     // transmitting a data byte
    ST_RD_ACK,    // sampling the master's ACK/NACK
    ST_IGNORE     // not addressed: wait for START/STOP
  } twi_slv_state_t;

  localparam logic TWI_RD = 1'b1;
  localparam logic TWI_WR = 1'b0;

  localparam int TWI_TICK_W = 8;
  typedef logic [TWI_TICK_W-1:0] twi_tick_t;

endpackage : twi_pkg

// File: rtl/twi_sync_edge.sv
// -----------------------------------------------------------------------------
// twi_sync_edge
// Two-flop synchronizer for an asynchronous bus line plus a third flop used
// for edge detection. Flops reset to 1, the idle level of a pulled-up bus.
// Ports:
//   clk      system clock
//   rst      synchronous reset, active-high
//   d_i      asynchronous input line
//   level_o  synchronized level
//   rise_o   one-cycle pulse on a synchronized 0->1 transition
//   fall_o   one-cycle pulse on a synchronized 1->0 transition
// -----------------------------------------------------------------------------
module twi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[1:0], d_i};
    end
  end

  assign level_o = sync_q[1];
  assign rise_o  = sync_q[1] & ~sync_q[2];
  assign fall_o  = ~sync_q[1] & sync_q[2];

endmodule : twi_sync_edge

// File: rtl/twi_slave.sv
// -----------------------------------------------------------------------------
// twi_slave
// TWI (I2C) target with one 7-bit chip address and a 256-byte register space
// exposed to a local host through write/read strobes. Supports register write
// (addr W, pointer, data...) and combined read (addr W, pointer, Sr, addr R,
// data...). SCL/SDA are oversampled on clk; SCL is never driven.
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   scl        TWI clock from the master (asynchronous)
//   sda        TWI data, open-drain (drives 0 or z)
//   reg_addr   register pointer presented to the host
//   reg_wdata  write data, valid while reg_we is high
//   reg_we     one-cycle write strobe
//   reg_re     one-cycle read strobe; reg_rdata is sampled the next cycle
//   reg_rdata  read data from the host
//   busy       high from a START until the next STOP
//   done       one-cycle pulse on a STOP ending an addressed transaction
// HOLD_CYC must be at least 3 so read data is loaded before it is driven.
// -----------------------------------------------------------------------------
module twi_slave
  import twi_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h2A,
  parameter twi_tick_t  HOLD_CYC   = twi_tick_t'(4)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       done
);

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;

  twi_sync_edge u_scl_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (scl),
    .level_o(scl_s),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  twi_sync_edge u_sda_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (sda),
    .level_o(sda_s),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = scl_s & sda_fall;
  assign stop_det  = scl_s & sda_rise;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  twi_slv_state_t state_q, state_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  twi_tick_t      hold_cnt_q, hold_cnt_d;
  logic           sda_oe_q, sda_oe_d;
  logic           first_byte_q, first_byte_d;
  logic           ptr_valid_q, ptr_valid_d;   // pointer received this transaction
  logic           dir_q, dir_d;
  logic           addressed_q, addressed_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [7:0]     reg_addr_q, reg_addr_d;
  logic [7:0]     reg_wdata_q, reg_wdata_d;
  logic           reg_we_q, reg_we_d;
  logic           reg_re_q, reg_re_d;
  logic           rd_load_q, rd_load_d;       // reg_re delayed: host data valid

  logic [7:0] rx_byte;
  logic       byte_end;
  logic       addr_ok;

  // Byte as it stands including the bit sampled on this SCL rise.
  assign rx_byte  = {shift_q[6:0], sda_s};
  assign byte_end = scl_rise && (bit_cnt_q == 4'd7);
  // A read address is only honoured once a pointer has been written.
  assign addr_ok  = (rx_byte[7:1] == SLAVE_ADDR) &&
                    ((rx_byte[0] == TWI_WR) || ptr_valid_q);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic; START/STOP override bit activity in every state.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = ST_ADDR;
    end else if (stop_det) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (byte_end) state_d = addr_ok ? ST_ADDR_ACK : ST_IGNORE;
        end
        ST_ADDR_ACK: begin
          // Leave on the SCL fall that ends the 9th clock.
          if (scl_fall && bit_cnt_q == 4'd1)
            state_d = (dir_q == TWI_WR) ? ST_WR_RX : ST_RD_TX;
        end
        ST_WR_RX: begin
          if (byte_end) state_d = ST_WR_ACK;
        end
        ST_WR_ACK: begin
          if (scl_fall && bit_cnt_q == 4'd1) state_d = ST_WR_RX;
        end
        ST_RD_TX: begin
          if (scl_fall && bit_cnt_q == 4'd8) state_d = ST_RD_ACK;
        end
        ST_RD_ACK: begin
          if (scl_rise && sda_s) state_d = ST_IGNORE;   // NACK
          else if (scl_fall)     state_d = ST_RD_TX;    // only reached after ACK
        end
        default: state_d = state_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    hold_cnt_d   = hold_cnt_q;
    sda_oe_d     = sda_oe_q;
    first_byte_d = first_byte_q;
    ptr_valid_d  = ptr_valid_q;
    dir_d        = dir_q;
    addressed_d  = addressed_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    reg_addr_d   = reg_addr_q;
    reg_wdata_d  = reg_wdata_q;
    reg_we_d     = 1'b0;
    reg_re_d     = 1'b0;
    rd_load_d    = reg_re_q;

    // Post-write increment follows an already issued strobe, even across STOP.
    if (reg_we_q) reg_addr_d = reg_addr_q + 8'd1;

    if (start_det) begin
      bit_cnt_d  = '0;
      hold_cnt_d = '0;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b1;
    end else if (stop_det) begin
      bit_cnt_d    = '0;
      hold_cnt_d   = '0;
      sda_oe_d     = 1'b0;
      busy_d       = 1'b0;
      done_d       = addressed_q;
      addressed_d  = 1'b0;
      ptr_valid_d  = 1'b0;
      first_byte_d = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (byte_end) begin
              bit_cnt_d = '0;
              if (addr_ok) begin
                addressed_d = 1'b1;
                dir_d       = rx_byte[0];
              end
            end
          end
        end
        ST_ADDR_ACK, ST_WR_ACK: begin
          // bit_cnt marks that the 9th SCL rise has been seen.
          if (scl_rise) begin
            bit_cnt_d = 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            bit_cnt_d = '0;
            if (state_q == ST_ADDR_ACK) begin
              if (dir_q == TWI_RD) reg_re_d     = 1'b1;
              else                 first_byte_d = 1'b1;
            end
          end
        end
        ST_WR_RX: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (byte_end) begin
              bit_cnt_d = '0;
              if (first_byte_q) begin
                reg_addr_d   = rx_byte;
                first_byte_d = 1'b0;
                ptr_valid_d  = 1'b1;
              end else begin
                reg_wdata_d = rx_byte;
                reg_we_d    = 1'b1;
              end
            end
          end
        end
        ST_RD_TX: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              bit_cnt_d  = '0;
              reg_addr_d = reg_addr_q + 8'd1;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise && !sda_s) reg_re_d = 1'b1;
        end
        default: ;
      endcase

      // SDA drive changes HOLD_CYC cycles after each SCL fall, using the state
      // entered at that fall.
      if (scl_fall) begin
        hold_cnt_d = HOLD_CYC;
      end else if (hold_cnt_q != '0) begin
        hold_cnt_d = hold_cnt_q - twi_tick_t'(1);
        if (hold_cnt_q == twi_tick_t'(1)) begin
          sda_oe_d = (state_q == ST_ADDR_ACK) || (state_q == ST_WR_ACK) ||
                     ((state_q == ST_RD_TX) && !shift_q[7]);
        end
      end
    end

    if (rd_load_q) shift_d = reg_rdata;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      hold_cnt_q   <= '0;
      sda_oe_q     <= 1'b0;
      first_byte_q <= 1'b0;
      ptr_valid_q  <= 1'b0;
      dir_q        <= TWI_WR;
      addressed_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      reg_addr_q   <= '0;
      reg_wdata_q  <= '0;
      reg_we_q     <= 1'b0;
      reg_re_q     <= 1'b0;
      rd_load_q    <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      hold_cnt_q   <= hold_cnt_d;
      sda_oe_q     <= sda_oe_d;
      first_byte_q <= first_byte_d;
      ptr_valid_q  <= ptr_valid_d;
      dir_q        <= dir_d;
      addressed_q  <= addressed_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
      reg_we_q     <= reg_we_d;
      reg_re_q     <= reg_re_d;
      rd_load_q    <= rd_load_d;
    end
  end

  // Open-drain: only ever pull low.
  assign sda       = sda_oe_q ? 1'b0 : 1'bz;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule : twi_slave

// File: tb/tb_twi_slave.sv
// -----------------------------------------------------------------------------
// tb_twi_slave
// Directed bench for twi_slave: a bit-banged TWI master, a host model that
// answers reg_re with a programmable byte, and a monitor logging strobes.
// -----------------------------------------------------------------------------
module tb_twi_slave;

  localparam int Q = 10;  // quarter SCL period in clk cycles

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       scl_m    = 1'b1;
  logic       sda_m_oe = 1'b0;
  wire        sda;
  logic [7:0] reg_addr, reg_wdata;
  logic [7:0] reg_rdata = 8'h00;
  logic       reg_we, reg_re, busy, done;
  logic [7:0] host_val  = 8'h00;

  int checks   = 0;
  int failures = 0;

  int         we_cnt = 0, re_cnt = 0, done_cnt = 0, slave_low_cnt = 0;
  logic [7:0] we_addr_log [4];
  logic [7:0] we_data_log [4];
  logic [7:0] re_addr_log = 8'h00;

  always #5 clk = ~clk;

  assign sda = sda_m_oe ? 1'b0 : 1'bz;
  pullup (sda);

  twi_slave #(
    .SLAVE_ADDR(7'h2A),
    .HOLD_CYC  (8'd4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl_m),
    .sda      (sda),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we   (reg_we),
    .reg_re   (reg_re),
    .reg_rdata(reg_rdata),
    .busy     (busy),
    .done     (done)
  );

  // Host: data valid the cycle after reg_re.
  always @(posedge clk) if (reg_re) reg_rdata <= host_val;

  // Monitor, sampled 1 ns after each rising edge.
  always begin
    @(posedge clk);
    #1;
    if (!rst) begin
      if (reg_we) begin
        if (we_cnt < 4) begin
          we_addr_log[we_cnt] = reg_addr;
          we_data_log[we_cnt] = reg_wdata;
        end
        we_cnt++;
      end
      if (reg_re) begin
        re_addr_log = reg_addr;
        re_cnt++;
      end
      if (done) done_cnt++;
      if (sda === 1'b0 && !sda_m_oe) slave_low_cnt++;
    end
  end

  // ---------------------------------------------------------------------------
  // Master primitives (all bus changes on the falling clk edge)
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    we_cnt = 0; re_cnt = 0; done_cnt = 0; slave_low_cnt = 0;
  endtask

  // Each bit starts and ends in the middle of the SCL low phase.
  task automatic send_bit(input logic b);
    sda_m_oe = ~b;
    tick(Q); scl_m = 1'b1;
    tick(2 * Q); scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic recv_bit(output logic b);
    sda_m_oe = 1'b0;
    tick(Q); scl_m = 1'b1;
    tick(Q); b = sda;
    tick(Q); scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic bus_start();
    sda_m_oe = 1'b0;
    tick(Q); scl_m = 1'b1;
    tick(Q); sda_m_oe = 1'b1;
    tick(Q); scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic bus_stop();
    sda_m_oe = 1'b1;
    tick(Q); scl_m = 1'b1;
    tick(Q); sda_m_oe = 1'b0;
    tick(2 * Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic nack);
    logic bit_v;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(bit_v);
      b[i] = bit_v;
    end
    send_bit(nack);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    tick(5);
    checks++; if (reg_addr !== 8'h00) begin failures++; $display("FAIL reset_reg_addr: got %h want 00", reg_addr); end
    checks++; if (reg_wdata !== 8'h00) begin failures++; $display("FAIL reset_reg_wdata: got %h want 00", reg_wdata); end
    checks++; if ({reg_we, reg_re} !== 2'b00) begin failures++; $display("FAIL reset_strobes: got %b want 00", {reg_we, reg_re}); end
    checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL reset_busy_done: got %b want 00", {busy, done}); end
    checks++; if (sda !== 1'b1) begin failures++; $display("FAIL reset_sda: got %b want 1", sda); end
    rst = 1'b0;
    tick(2 * Q);
  endtask

  task automatic test_write_single();
    logic a0, a1, a2;
    clear_logs();
    bus_start();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr_busy_high: got %b want 1", busy); end
    send_byte(8'h54, a0);
    send_byte(8'h10, a1);
    send_byte(8'hA5, a2);
    bus_stop();
    checks++; if ({a0, a1, a2} !== 3'b000) begin failures++; $display("FAIL wr_acks: got %b want 000", {a0, a1, a2}); end
    checks++; if (we_cnt !== 1) begin failures++; $display("FAIL wr_we_count: got %0d want 1", we_cnt); end
    checks++; if (we_addr_log[0] !== 8'h10) begin failures++; $display("FAIL wr_addr: got %h want 10", we_addr_log[0]); end
    checks++; if (we_data_log[0] !== 8'hA5) begin failures++; $display("FAIL wr_data: got %h want a5", we_data_log[0]); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL wr_done: got %0d want 1", done_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr_busy_low: got %b want 0", busy); end
    checks++; if (reg_addr !== 8'h11) begin failures++; $display("FAIL wr_addr_incr: got %h want 11", reg_addr); end
  endtask

  task automatic test_combined_read();
    logic a0, a1, a2;
    logic [7:0] rx;
    host_val = 8'h3C;
    clear_logs();
    bus_start();
    send_byte(8'h54, a0);
    send_byte(8'h20, a1);
    bus_start();
    send_byte(8'h55, a2);
    recv_byte(rx, 1'b1);
    bus_stop();
    checks++; if ({a0, a1, a2} !== 3'b000) begin failures++; $display("FAIL rd_acks: got %b want 000", {a0, a1, a2}); end
    checks++; if (rx !== 8'h3C) begin failures++; $display("FAIL rd_data: got %h want 3c", rx); end
    checks++; if (re_cnt !== 1) begin failures++; $display("FAIL rd_re_count: got %0d want 1", re_cnt); end
    checks++; if (re_addr_log !== 8'h20) begin failures++; $display("FAIL rd_re_addr: got %h want 20", re_addr_log); end
    checks++; if (we_cnt !== 0) begin failures++; $display("FAIL rd_no_we: got %0d want 0", we_cnt); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL rd_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_wrong_addr();
    logic a0, a1, a2;
    clear_logs();
    bus_start();
    send_byte(8'h56, a0);
    send_byte(8'h10, a1);
    send_byte(8'h55, a2);
    bus_stop();
    checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL bad_addr_acks: got %b want 111", {a0, a1, a2}); end
    checks++; if (slave_low_cnt !== 0) begin failures++; $display("FAIL bad_addr_sda_driven: got %0d want 0", slave_low_cnt); end
    checks++; if (we_cnt !== 0) begin failures++; $display("FAIL bad_addr_we: got %0d want 0", we_cnt); end
    checks++; if (done_cnt !== 0) begin failures++; $display("FAIL bad_addr_done: got %0d want 0", done_cnt); end
  endtask

  task automatic test_burst_write();
    logic a0, a1, a2, a3;
    clear_logs();
    bus_start();
    send_byte(8'h54, a0);
    send_byte(8'hFF, a1);
    send_byte(8'h11, a2);
    send_byte(8'h22, a3);
    bus_stop();
    checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin failures++; $display("FAIL burst_acks: got %b want 0000", {a0, a1, a2, a3}); end
    checks++; if (we_cnt !== 2) begin failures++; $display("FAIL burst_we_count: got %0d want 2", we_cnt); end
    checks++; if ({we_addr_log[0], we_data_log[0]} !== 16'hFF11) begin failures++; $display("FAIL burst_first: got %h want ff11", {we_addr_log[0], we_data_log[0]}); end
    checks++; if ({we_addr_log[1], we_data_log[1]} !== 16'h0022) begin failures++; $display("FAIL burst_wrap: got %h want 0022", {we_addr_log[1], we_data_log[1]}); end
  endtask

  task automatic test_stop_mid_byte();
    logic a0, a1;
    clear_logs();
    bus_start();
    send_byte(8'h54, a0);
    send_byte(8'h40, a1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    bus_stop();
    checks++; if ({a0, a1} !== 2'b00) begin failures++; $display("FAIL partial_acks: got %b want 00", {a0, a1}); end
    checks++; if (we_cnt !== 0) begin failures++; $display("FAIL partial_no_we: got %0d want 0", we_cnt); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL partial_done: got %0d want 1", done_cnt); end
    checks++; if (sda !== 1'b1) begin failures++; $display("FAIL partial_sda: got %b want 1", sda); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL partial_busy: got %b want 0", busy); end
    checks++; if (reg_addr !== 8'h40) begin failures++; $display("FAIL partial_ptr: got %h want 40", reg_addr); end
  endtask

  task automatic test_reset_mid_ack();
    logic a0, a1, a2;
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h54 >> i));
    sda_m_oe = 1'b0;
    tick(2);
    checks++; if (sda !== 1'b0) begin failures++; $display("FAIL rst_ack_driven: got %b want 0", sda); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (sda !== 1'b1) begin failures++; $display("FAIL rst_sda_release: got %b want 1", sda); end
    tick(4);
    rst = 1'b0;
    tick(2);
    checks++; if ({reg_addr, reg_wdata} !== 16'h0000) begin failures++; $display("FAIL rst_regs: got %h want 0000", {reg_addr, reg_wdata}); end
    checks++; if ({reg_we, reg_re, busy, done} !== 4'b0000) begin failures++; $display("FAIL rst_ctrl: got %b want 0000", {reg_we, reg_re, busy, done}); end
    // Return the bus to idle with a STOP, then run a full write.
    sda_m_oe = 1'b1;
    tick(Q); scl_m = 1'b1;
    tick(Q); sda_m_oe = 1'b0;
    tick(2 * Q);
    clear_logs();
    bus_start();
    send_byte(8'h54, a0);
    send_byte(8'h33, a1);
    send_byte(8'h5A, a2);
    bus_stop();
    checks++; if ({a0, a1, a2} !== 3'b000) begin failures++; $display("FAIL rst_recover_acks: got %b want 000", {a0, a1, a2}); end
    checks++; if (we_cnt !== 1) begin failures++; $display("FAIL rst_recover_we: got %0d want 1", we_cnt); end
    checks++; if ({we_addr_log[0], we_data_log[0]} !== 16'h335A) begin failures++; $display("FAIL rst_recover_data: got %h want 335a", {we_addr_log[0], we_data_log[0]}); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL rst_recover_done: got %0d want 1", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_write_single();
    test_combined_read();
    test_wrong_addr();
    test_burst_write();
    test_stop_mid_byte();
    test_reset_mid_ack();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_twi_slave
